// File: rtl/vga_sync.sv
// VGA timing generator: h/v counters, blanked RGB and active-low syncs with matched latency.
// Optional macro PIXEL_TICK_DIV_EN divides clk by 4 to produce the pixel enable.
module vga_sync #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] color_in,
    output logic        p_tick,
    output logic [9:0]  p_col,
    output logic [9:0]  p_row,
    output logic        video_on,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

`ifdef PIXEL_TICK_DIV_EN
    logic [1:0] div_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= 2'd0;
        end else begin
            div_q <= div_q + 2'd1;
        end
    end

    assign p_tick = (div_q == 2'd3);
`else
    assign p_tick = 1'b1;
`endif

    logic [9:0]  h_q, h_d, v_q, v_d;
    logic        hsync_raw, vsync_raw;
    logic        hsync_q, vsync_q;
    logic [11:0] rgb_q;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (p_tick) begin
            if (h_q >= H_MAX) begin
                h_d = 10'd0;
                v_d = (v_q >= V_MAX) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    always_comb begin
        video_on    = (h_q < H_VIS) && (v_q < V_VIS);
        hsync_raw   = !((h_q >= HS_START) && (h_q <= HS_END));
        vsync_raw   = !((v_q >= VS_START) && (v_q <= VS_END));
        frame_start = p_tick && (h_q == H_MAX) && (v_q == V_MAX);
    end

    // Sync and pixel share one register stage so they stay aligned at the DAC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q     <= 10'd0;
            v_q     <= 10'd0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= 12'h000;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
            if (p_tick) begin
                hsync_q <= hsync_raw;
                vsync_q <= vsync_raw;
                rgb_q   <= video_on ? color_in : 12'h000;
            end
        end
    end

    assign p_col = h_q;
    assign p_row = v_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign rgb   = rgb_q;

endmodule
